// File: rtl/regfile_sb_if.sv
// regfile_sb_if: decode/write-back bundle for the scoreboarded register file.
interface regfile_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     iss_valid;
    logic [ADDR_W-1:0]        iss_addr;
    logic [1:0]               wr_en;
    logic [2*ADDR_W-1:0]      wr_addr;
    logic [2*DATA_W-1:0]      wr_data;
    logic                     flush;
    logic [ADDR_W:0]          busy_cnt;

    modport master (
        output rd_addr, iss_valid, iss_addr, wr_en, wr_addr, wr_data, flush,
        input  rd_data, rd_busy, busy_cnt
    );

    modport slave (
        input  rd_addr, iss_valid, iss_addr, wr_en, wr_addr, wr_data, flush,
        output rd_data, rd_busy, busy_cnt
    );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: register file with two write-back ports, same-cycle bypass and busy scoreboard.
module regfile_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input logic         clk,
    input logic         rst,
    regfile_sb_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy, busy_nxt, wr_hit;
    logic [ADDR_W:0]   cnt, cnt_nxt;
    logic [ADDR_W-1:0] wa0, wa1;
    logic [DATA_W-1:0] wd0, wd1;
    logic              we0, we1;

    assign wa0 = bus.wr_addr[0 +: ADDR_W];
    assign wa1 = bus.wr_addr[ADDR_W +: ADDR_W];
    assign wd0 = bus.wr_data[0 +: DATA_W];
    assign wd1 = bus.wr_data[DATA_W +: DATA_W];
    assign we0 = bus.wr_en[0] && wa0 != '0;
    assign we1 = bus.wr_en[1] && wa1 != '0;

    always_comb begin
        wr_hit = '0;
        if (we0) wr_hit[wa0] = 1'b1;
        if (we1) wr_hit[wa1] = 1'b1;
    end

    // Issue is applied after write-back clears so a new producer stays outstanding.
    always_comb begin
        busy_nxt = busy & ~wr_hit;
        if (bus.iss_valid) busy_nxt[bus.iss_addr] = 1'b1;
        busy_nxt[0] = 1'b0;
        if (bus.flush) busy_nxt = '0;
        cnt_nxt = '0;
        for (int r = 0; r < DEPTH; r++) cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, busy_nxt[r]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
            cnt  <= '0;
        end else begin
            busy <= busy_nxt;
            cnt  <= cnt_nxt;
        end
    end

    // Port 1 is written last so it wins a same-address conflict.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (we0) mem[wa0] <= wd0;
            if (we1) mem[wa1] <= wd1;
        end
    end

    assign bus.busy_cnt = cnt;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] a;
        assign a = bus.rd_addr[k*ADDR_W +: ADDR_W];
        assign bus.rd_data[k*DATA_W +: DATA_W] = a == '0 ? '0 :
                                                 (we1 && wa1 == a) ? wd1 :
                                                 (we0 && wa0 == a) ? wd0 : mem[a];
        assign bus.rd_busy[k] = busy[a] & ~wr_hit[a];
    end
endmodule
